fft_out_reorder: RTL and testbench
==================================

// Module: fft_out_reorder
// PURPOSE
// - Output reorder buffer that sits directly after the 4-lane parallel FFT core.
// - Accepts 4 complex samples per clock, arriving in bit-reversed order, and stores them in a ping-pong (2-bank) frame buffer.
// - Drains each frame in natural order, 4 samples per clock, under a valid/ready handshake.
// - Upstream cannot stall, so a frame that finds no free bank is dropped and the drop is flagged.
// PARAMETERS
// - NBITS_OUT  15   bits per real/imag part; a complex word is {re,im}, 2*NBITS_OUT wide.
// - N          128  FFT frame length. Power of two, >= 8. AW = log2(N). Frame = N/4 input cycles.
// PORTS
// - clk            in   1      clock, rising edge.
// - rst            in   1      asynchronous, active-low reset.
// - i_enable       in   1      upstream output-valid; a lane group is written every cycle it is high.
// - i_data0_up     in   2*NB   lane 0 ({re,im}, NB = NBITS_OUT).
// - i_data0_down   in   2*NB   lane 1.
// - i_data1_up     in   2*NB   lane 2.
// - i_data1_down   in   2*NB   lane 3.
// - o_data0        out  2*NB   natural-order sample 4r+0.
// - o_data1        out  2*NB   natural-order sample 4r+1.
// - o_data2        out  2*NB   natural-order sample 4r+2.
// - o_data3        out  2*NB   natural-order sample 4r+3.
// - o_valid        out  1      o_data* holds a valid beat.
// - o_last         out  1      beat r = N/4-1 of a frame; qualified by o_valid.
// - i_ready        in   1      downstream accepts a beat when o_valid & i_ready.
// - o_ovf          out  1      sticky; set when a frame is dropped. Cleared only by rst.
// BEHAVIOUR
// - Reset: o_data*=0, o_valid=0, o_last=0, o_ovf=0. Both banks EMPTY. Write counter c=0, read counter r=0.
// - Write side, counter c over 0..N/4-1:
//   - Advances on each cycle with i_enable=1; wraps to 0 after N/4-1.
//   - At c=0 a write bank is allocated: lowest-index EMPTY bank.
//   - If no bank is EMPTY, the whole frame is dropped: no writes, o_ovf<=1, c still advances.
//   - Lane k (0..3) at cycle c has arrival index idx=4c+k. It is written to addr bitrev_AW(idx).
//   - The bank becomes FULL on the clock edge of the c=N/4-1 write.
// - i_enable falls mid-frame: the partial bank returns to EMPTY, c<=0. No flag is raised.
// - Bank states: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
// - Read side: the bank order is FIFO. The oldest FULL bank goes to DRAINING.
// - Output register loads when (!o_valid | i_ready) and a DRAINING/FULL bank has beats left.
//   - Load: o_dataK <= mem[bank][4r+K], o_last <= (r==N/4-1), r++.
// - If nothing can be loaded and i_ready=1, o_valid<=0.
// - o_valid & !i_ready: o_data*, o_valid and o_last hold unchanged.
// - The drained bank returns to EMPTY on the cycle its o_last beat is loaded into the output register.
// - Latency: last input beat on cycle T gives o_valid=1 with samples 0..3 at T+2 (i_ready high, bank free).
// - Back-to-back frames drain without bubbles when i_ready is held high.
// - Same-cycle release and allocate: a bank released this cycle is NOT usable by a c=0 allocation this same cycle.
//   - With continuous i_enable and i_ready=1, 2 banks are sufficient. No drops.
// - Simultaneous FULL transition and read start: not possible on the same bank.
// - Reset mid-operation: immediate return to the reset state. Buffer contents are don't-care.
// - Storage: 2*N words of 2*NB bits in a reg array. Four writes per cycle, four reads per cycle.
// CONFIGURATION
// - Macro FFT_REORDER_DROPCNT_EN.
// - Defined: adds port o_drop_cnt, out, 16 bits.
//   - Counts dropped frames, saturating at 16'hFFFF. Reset value 0.
//   - Increments on the same cycle o_ovf would be set.
// - Undefined: the port and the counter do not exist. All other behaviour is identical.
// TESTING
// - Ramp: i_enable=1 for N/4 cycles. Lane k at cycle c carries re=im=4c+k. i_ready=1.
//   -> at T+2, o_data0..3 = bitrev7(0..3) = 0,64,32,96.
//   -> N/4 beats total; o_last only on beat 31.
// - Continuous streaming of 4 frames, i_ready=1. -> 128 output beats, no gaps after the first, o_ovf stays 0.
// - i_ready=0 for the whole of frames 1-3. -> frame 3 dropped, o_ovf=1, drop count 1 (with macro).
//   -> frames 1-2 then drain intact in order once i_ready=1.
// - i_ready toggled 1,0,1,0 during a drain. -> o_data* held during i_ready=0. No beat lost or duplicated.
// - i_enable low at c=10 of a frame, then a new full frame.
//   -> only the new frame is output, with the ramp check passing. o_ovf=0.
// - rst low for 1 cycle mid-drain.
//   -> o_valid=0, o_ovf=0 immediately. The next frame drains correctly.

Source files
------------

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: bit-reversed 4-lane FFT output to natural order, ping-pong banks.
// Optional FFT_REORDER_DROPCNT_EN adds a saturating dropped-frame counter port.
module fft_out_reorder #(
  parameter int NBITS_OUT = 15,
  parameter int N         = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enable,
  input  logic [2*NBITS_OUT-1:0] i_data0_up,
  input  logic [2*NBITS_OUT-1:0] i_data0_down,
  input  logic [2*NBITS_OUT-1:0] i_data1_up,
  input  logic [2*NBITS_OUT-1:0] i_data1_down,
  output logic [2*NBITS_OUT-1:0] o_data0,
  output logic [2*NBITS_OUT-1:0] o_data1,
  output logic [2*NBITS_OUT-1:0] o_data2,
  output logic [2*NBITS_OUT-1:0] o_data3,
  output logic                   o_valid,
  output logic                   o_last,
  input  logic                   i_ready,
  output logic                   o_ovf
`ifdef FFT_REORDER_DROPCNT_EN
  ,
  output logic [15:0]            o_drop_cnt
`endif
);

  localparam int W     = 2 * NBITS_OUT;
  localparam int AW    = $clog2(N);
  localparam int CW    = AW - 2;
  localparam int NBEAT = N / 4;
  localparam logic [CW-1:0] LAST = CW'(NBEAT - 1);

  typedef enum logic [1:0] {
    B_EMPTY,
    B_FILL,
    B_FULL,
    B_DRAIN
  } bank_e;

  bank_e         st_q [2];
  logic [CW-1:0] c_q;
  logic [CW-1:0] r_q;
  logic          wbank_q;
  logic          wdrop_q;
  logic          oldest_q;
  logic [W-1:0]  mem_q [2][N];

  logic          any_empty;
  logic          free_bank;
  logic          wr_en;
  logic          wr_bank;
  logic          rd_ok;
  logic          rd_bank;
  logic          rd_ld;
  logic [AW-1:0] rd_base;
  logic [AW-1:0] wa [4];

`ifdef FFT_REORDER_DROPCNT_EN
  logic [15:0]   drop_cnt_q;
  assign o_drop_cnt = drop_cnt_q;
`endif

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  // Write-bank allocation and scattered (bit-reversed) write addresses
  always_comb begin
    any_empty = (st_q[0] == B_EMPTY) || (st_q[1] == B_EMPTY);
    free_bank = (st_q[0] == B_EMPTY) ? 1'b0 : 1'b1;
    if (c_q == '0) begin
      wr_en   = i_enable && any_empty;
      wr_bank = free_bank;
    end else begin
      wr_en   = i_enable && !wdrop_q;
      wr_bank = wbank_q;
    end
    for (int k = 0; k < 4; k++) wa[k] = bitrev({c_q, 2'(k)});
  end

  // Read bank choice: keep draining, else oldest FULL bank
  always_comb begin
    rd_ok   = 1'b1;
    rd_bank = 1'b0;
    if (st_q[0] == B_DRAIN) begin
      rd_bank = 1'b0;
    end else if (st_q[1] == B_DRAIN) begin
      rd_bank = 1'b1;
    end else if (st_q[0] == B_FULL && st_q[1] == B_FULL) begin
      rd_bank = oldest_q;
    end else if (st_q[0] == B_FULL) begin
      rd_bank = 1'b0;
    end else if (st_q[1] == B_FULL) begin
      rd_bank = 1'b1;
    end else begin
      rd_ok = 1'b0;
    end
    rd_ld   = rd_ok && (!o_valid || i_ready);
    rd_base = {r_q, 2'b00};
  end

  // Frame storage, contents need no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_bank][wa[0]] <= i_data0_up;
      mem_q[wr_bank][wa[1]] <= i_data0_down;
      mem_q[wr_bank][wa[2]] <= i_data1_up;
      mem_q[wr_bank][wa[3]] <= i_data1_down;
    end
  end

  // Bank states, write/read counters and registered output beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q[0]  <= B_EMPTY;
      st_q[1]  <= B_EMPTY;
      c_q      <= '0;
      r_q      <= '0;
      wbank_q  <= 1'b0;
      wdrop_q  <= 1'b0;
      oldest_q <= 1'b0;
      o_data0  <= '0;
      o_data1  <= '0;
      o_data2  <= '0;
      o_data3  <= '0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
      o_ovf    <= 1'b0;
`ifdef FFT_REORDER_DROPCNT_EN
      drop_cnt_q <= '0;
`endif
    end else begin
      if (i_enable) begin
        if (c_q == '0) begin
          if (any_empty) begin
            wbank_q          <= free_bank;
            wdrop_q          <= 1'b0;
            st_q[free_bank]  <= B_FILL;
          end else begin
            wdrop_q <= 1'b1;
            o_ovf   <= 1'b1;
`ifdef FFT_REORDER_DROPCNT_EN
            if (drop_cnt_q != 16'hFFFF)
              drop_cnt_q <= drop_cnt_q + 16'd1;
`endif
          end
        end else if (c_q == LAST && !wdrop_q) begin
          st_q[wbank_q] <= B_FULL;
          if (st_q[~wbank_q] != B_FULL)
            oldest_q <= wbank_q;
        end
        c_q <= (c_q == LAST) ? '0 : c_q + 1'b1;
      end else if (c_q != '0) begin
        if (!wdrop_q)
          st_q[wbank_q] <= B_EMPTY;
        c_q <= '0;
      end

      if (rd_ld) begin
        o_data0 <= mem_q[rd_bank][rd_base];
        o_data1 <= mem_q[rd_bank][rd_base | AW'(1)];
        o_data2 <= mem_q[rd_bank][rd_base | AW'(2)];
        o_data3 <= mem_q[rd_bank][rd_base | AW'(3)];
        o_valid <= 1'b1;
        o_last  <= (r_q == LAST);
        if (r_q == LAST) begin
          r_q           <= '0;
          st_q[rd_bank] <= B_EMPTY;
        end else begin
          r_q           <= r_q + 1'b1;
          st_q[rd_bank] <= B_DRAIN;
        end
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: scoreboard bench for the FFT output reorder buffer.
// Expected beats come from a natural-order model of each issued frame.
module tb_fft_out_reorder;

  localparam int NB    = 15;
  localparam int N     = 128;
  localparam int W     = 2 * NB;
  localparam int AW    = 7;
  localparam int NBEAT = N / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_enable = 1'b0;
  logic         i_ready = 1'b1;
  logic [W-1:0] d0u = '0, d0d = '0, d1u = '0, d1d = '0;
  logic [W-1:0] o_data0, o_data1, o_data2, o_data3;
  logic         o_valid, o_last, o_ovf;
`ifdef FFT_REORDER_DROPCNT_EN
  logic [15:0]  o_drop_cnt;
`endif

  fft_out_reorder #(.NBITS_OUT(NB), .N(N)) dut (
    .clk(clk),
    .rst(rst),
    .i_enable(i_enable),
    .i_data0_up(d0u),
    .i_data0_down(d0d),
    .i_data1_up(d1u),
    .i_data1_down(d1d),
    .o_data0(o_data0),
    .o_data1(o_data1),
    .o_data2(o_data2),
    .o_data3(o_data3),
    .o_valid(o_valid),
    .o_last(o_last),
    .i_ready(i_ready),
    .o_ovf(o_ovf)
`ifdef FFT_REORDER_DROPCNT_EN
    ,
    .o_drop_cnt(o_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pushed_frames = 0;
  int done_frames = 0;
  logic [4*W:0] sbq [$];
  logic [4*W:0] mon_e;
  logic [4*W:0] prev_out;
  logic         prev_stall = 1'b0;
  bit           stop_ready = 1'b0;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  function automatic logic [W-1:0] rw(input int v);
    return {NB'(v), NB'(v)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one frame; ncyc < NBEAT gives an aborted partial frame
  task automatic send_frame(input bit ramp, input bit expect_out,
                            input int ncyc);
    logic [W-1:0] s [N];
    logic [4*W:0] e;
    for (int i = 0; i < N; i++)
      s[i] = ramp ? rw(i) : W'($urandom);
    if (expect_out && ncyc == NBEAT) begin
      for (int r = 0; r < NBEAT; r++) begin
        e = {r == NBEAT - 1,
             s[bitrev(AW'(4*r+3))], s[bitrev(AW'(4*r+2))],
             s[bitrev(AW'(4*r+1))], s[bitrev(AW'(4*r))]};
        sbq.push_back(e);
      end
      pushed_frames++;
    end
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      i_enable = 1'b1;
      d0u = s[4*c];
      d0d = s[4*c+1];
      d1u = s[4*c+2];
      d1d = s[4*c+3];
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    i_enable = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while ((sbq.size() != 0 || o_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_budget", n < budget, 1);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: pops expected beats on every handshake, checks stall hold
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold", {o_valid, o_last, o_data3, o_data2, o_data1, o_data0},
            {1'b1, prev_out});
      if (o_valid && i_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none",
                   {o_last, o_data3, o_data2, o_data1, o_data0});
        end else begin
          mon_e = sbq.pop_front();
          chk("beat", {o_last, o_data3, o_data2, o_data1, o_data0}, mon_e);
          if (mon_e[4*W]) done_frames++;
        end
      end
      prev_stall = o_valid && !i_ready;
      prev_out   = {o_last, o_data3, o_data2, o_data1, o_data0};
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gaps;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_last", o_last, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_data", {o_data3, o_data2, o_data1, o_data0}, 0);
    rst = 1'b1;

    // Ramp frame: latency and first beat
    send_frame(1, 1, NBEAT);
    idle();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_valid && n < 10);
    chk("latency", n, 2);
    chk("ramp_beat0", {o_data3, o_data2, o_data1, o_data0},
        {rw(96), rw(32), rw(64), rw(0)});
    wait_empty(200);

    // Four back-to-back frames, no output gaps
    fork
      begin
        repeat (4) send_frame(0, 1, NBEAT);
        idle();
      end
      begin
        n = 0;
        @(negedge clk);
        while (!o_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        gaps = 0;
        for (int i = 1; i < 4 * NBEAT; i++) begin
          @(negedge clk);
          if (!o_valid) gaps++;
        end
        chk("no_gaps", gaps, 0);
      end
    join
    wait_empty(300);
    chk("ovf_stream", o_ovf, 0);

    // Stalled sink: third frame must be dropped
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    send_frame(0, 1, NBEAT);
    send_frame(0, 1, NBEAT);
    send_frame(0, 0, NBEAT);
    idle();
    repeat (2) @(negedge clk);
    chk("ovf_set", o_ovf, 1);
    chk("stall_valid", o_valid, 1);
`ifdef FFT_REORDER_DROPCNT_EN
    chk("drop_cnt", o_drop_cnt, 1);
`endif
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    wait_empty(300);

    // Random i_ready with at most two frames in flight
    stop_ready = 1'b0;
    fork
      begin
        while (!stop_ready) begin
          @(posedge clk);
          #1;
          i_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int f = 0; f < 4; f++) begin
          n = 0;
          while (pushed_frames - done_frames > 1 && n < 3000) begin
            @(negedge clk);
            n++;
          end
          chk("inflight_budget", n < 3000, 1);
          send_frame(0, 1, NBEAT);
          idle();
        end
        stop_ready = 1'b1;
      end
    join
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    wait_empty(600);
    chk("ovf_sticky", o_ovf, 1);

    // Reset pulse in the middle of a drain
    send_frame(0, 1, NBEAT);
    idle();
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    pushed_frames = 0;
    done_frames = 0;
    #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_ovf", o_ovf, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_frame(1, 1, NBEAT);
    idle();
    wait_empty(200);

    // Aborted partial frame, then a full ramp frame
    send_frame(1, 0, 10);
    idle();
    send_frame(1, 1, NBEAT);
    idle();
    wait_empty(200);
    chk("ovf_abort", o_ovf, 0);
    chk("frames_done", done_frames, 2);
    chk("sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
